mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle control unit for the 16-bit core.
- Receives the opcode (instr[15:12]) and condition field (instr[1:0]) from the datapath instruction register, plus the datapath zero output and the architectural carry/zero flags.
- Sequences fetch, decode, execute, memory and writeback as a Moore FSM and drives every datapath enable and mux select.
- Sits directly upstream of the datapath inside the core top level.

Parameters:
- STATE_W, 4, width of the state register and of the dbg_state port.
- RESET_VEC_SEL, 0, retained field; no effect on behaviour (PC reset is owned by the datapath).

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  4  opcode instr[15:12]
- cz  in  2  condition field instr[1:0]
- zero  in  1  ALU zero output (same cycle)
- carry_flag  in  1  architectural carry flag
- zero_flag  in  1  architectural zero flag
- pcen  out  1  PC load enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- flagwrite  out  1  carry/zero flag register load
- alusrca  out  1  0 = PC, 1 = reg A
- iord  out  1  0 = PC address, 1 = ALUOut address
- memtoreg  out  1  0 = ALUOut, 1 = memory data register
- regdst  out  2  00 = rt, 01 = rd, 10 = r7 (link)
- alusrcb  out  2  00 = reg B, 01 = const 1, 10 = sext imm6, 11 = imm9 << 7
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = reg A
- alucontrol  out  3  000 add, 001 nand, 010 sub, 011 pass-B
- illegal  out  1  one-cycle pulse on an undefined opcode
- dbg_state  out  STATE_W  current state

Behaviour:
- Opcodes:
  - 0000 ADD
  - 0010 NAND
  - 0001 ADI
  - 0011 LHI
  - 0100 LW
  - 0101 SW
  - 1100 BEQ
  - 1000 JAL
  - 1001 JLR
  - All others are illegal.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, ADIEX=8, ADIWB=9, LHIWB=10, BEQEX=11, JALEX=12, JLREX=13. Codes 14 and 15 go to FETCH.
- Reset: sampled on the clock edge; the state register loads FETCH. While reset is high, all outputs are forced to 0 combinationally, including dbg_state.
- Outputs are decoded from state only. The exception is pcen = pcwrite | (branch & zero). Any signal not listed for a state is 0.
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=000, pcsrc=00, pcwrite=1. Next state is DECODE.
- DECODE: alusrca=0, alusrcb=10, alucontrol=000 (branch target to ALUOut).
  - LW or SW goes to MEMADR.
  - ADD or NAND goes to RTEX.
  - ADI goes to ADIEX; LHI goes to LHIWB; BEQ goes to BEQEX; JAL goes to JALEX; JLR goes to JLREX.
  - Illegal opcode goes to FETCH and pulses illegal for this cycle.
- MEMADR: alusrca=1, alusrcb=10, add. LW goes to MEMRD; SW goes to MEMWR.
- MEMRD: iord=1. Next state is MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=00. Next state is FETCH.
- MEMWR: iord=1, memwrite=1. Next state is FETCH.
- RTEX: alusrca=1, alusrcb=00, alucontrol = 000 (ADD) or 001 (NAND), flagwrite=1. Next state is RTWB.
- RTWB: regwrite=wb_ok, regdst=01, memtoreg=0. Next state is FETCH.
- ADIEX: alusrca=1, alusrcb=10, add, flagwrite=1. Next state is ADIWB.
- ADIWB: regwrite=1, regdst=00. Next state is FETCH.
- LHIWB: alusrcb=11, alucontrol=011, regwrite=1, regdst=00, memtoreg=0. ALU result is written directly. Next state is FETCH.
- BEQEX: alusrca=1, alusrcb=00, alucontrol=010, branch=1, pcsrc=01. Next state is FETCH.
- JALEX: regwrite=1, regdst=10, alusrca=0, alusrcb=01 (link = PC, already incremented), pcsrc=01, pcwrite=1. Next state is FETCH.
- JLREX: regwrite=1, regdst=10, pcsrc=10, pcwrite=1. Next state is FETCH.
- Instruction latency in cycles, FETCH to FETCH:
  - 5: LW
  - 4: SW, ADD, NAND, ADI
  - 3: LHI, BEQ, JAL, JLR
  - 2: illegal
- memwrite and regwrite are never both 1 in the same cycle.
- Reset mid-instruction: the in-flight instruction is abandoned and no write occurs in the reset cycle.
- wb_ok is 1 unless COND_WB_EN applies (see Optional Feature).

Optional Feature:
- Macro: COND_WB_EN.
- Defined: wb_ok is determined by cz:
  - cz=00: wb_ok=1
  - cz=01: wb_ok=zero_flag
  - cz=10: wb_ok=carry_flag
  - cz=11: wb_ok=0
  - flagwrite in RTEX is gated by wb_ok.
- Undefined: cz is ignored, wb_ok=1, and flagwrite in RTEX is always 1.

Test Plan:
- Reset:
  - Stimulus: reset high for 2 cycles, then low.
  - Required: every output is 0 during reset. Cycle 1 after release shows dbg_state=0, irwrite=1, pcen=1, alusrcb=01, iord=0.
- ADD:
  - Stimulus: op=0000, cz=00.
  - Required: states 0,1,6,7,0. RTWB has regwrite=1 and regdst=01. RTEX has flagwrite=1 and alucontrol=000.
- LW then SW:
  - Stimulus: op=0100, then op=0101.
  - Required: LW states 0,1,2,3,4 with regwrite=1 and memtoreg=1 in state 4. SW states 0,1,2,5 with memwrite=1 only in state 5 and iord=1 there.
- BEQ:
  - Stimulus: op=1100 with zero=1, then with zero=0.
  - Required: pcen=1 in BEQEX for zero=1 and pcen=0 for zero=0. alucontrol=010 and pcsrc=01 in both cases.
- Conditional writeback:
  - Stimulus: ADD with cz=01 and zero_flag=0.
  - Required: with COND_WB_EN defined, regwrite=0 in RTWB and flagwrite=0 in RTEX. With it undefined, regwrite=1.
- Illegal opcode and reset mid-instruction:
  - Stimulus: op=1111, then a separate run asserting reset during MEMWR.
  - Required: for op=1111, states 0,1,0 with illegal=1 for exactly the DECODE cycle. For the reset run, memwrite=0 in the reset cycle and dbg_state=0 in the following cycle.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_fsm_if
//  Purpose  : Control bus between the multicycle control FSM and the datapath.
//             The master side is the control unit: it receives instruction
//             fields and flags, and it drives every enable and mux select.
//             The slave side is the datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface mc_control_fsm_if #(
  parameter int STATE_W = 4
);
  // Datapath to control unit
  logic [3:0]         op;
  logic [1:0]         cz;
  logic               zero;
  logic               carry_flag;
  logic               zero_flag;

  // Control unit to datapath
  logic               pcen;
  logic               memwrite;
  logic               irwrite;
  logic               regwrite;
  logic               flagwrite;
  logic               alusrca;
  logic               iord;
  logic               memtoreg;
  logic [1:0]         regdst;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [2:0]         alucontrol;
  logic               illegal;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  op, cz, zero, carry_flag, zero_flag,
    output pcen, memwrite, irwrite, regwrite, flagwrite, alusrca, iord,
           memtoreg, regdst, alusrcb, pcsrc, alucontrol, illegal, dbg_state
  );

  modport slave (
    output op, cz, zero, carry_flag, zero_flag,
    input  pcen, memwrite, irwrite, regwrite, flagwrite, alusrca, iord,
           memtoreg, regdst, alusrcb, pcsrc, alucontrol, illegal, dbg_state
  );
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control_fsm
//  Purpose  : Moore-style multicycle control unit for the 16-bit core.
//             It sequences fetch, decode, execute, memory and writeback, and
//             it drives all datapath enables and selects through the control
//             bus interface.
//  Options  : COND_WB_EN - when defined, the cz field gates register
//             writeback and the flag update of ADD/NAND.
//  Revision : 1.0  initial release
// ============================================================================
module mc_control_fsm #(
  parameter int STATE_W       = 4,
  parameter int RESET_VEC_SEL = 0   // retained field; PC reset lives in the datapath
) (
  input  wire                clk,
  input  wire                reset,
  mc_control_fsm_if.master   bus
);

  // Opcodes (instr[15:12])
  localparam logic [3:0] c_OP_ADD  = 4'b0000;
  localparam logic [3:0] c_OP_ADI  = 4'b0001;
  localparam logic [3:0] c_OP_NAND = 4'b0010;
  localparam logic [3:0] c_OP_LHI  = 4'b0011;
  localparam logic [3:0] c_OP_LW   = 4'b0100;
  localparam logic [3:0] c_OP_SW   = 4'b0101;
  localparam logic [3:0] c_OP_JAL  = 4'b1000;
  localparam logic [3:0] c_OP_JLR  = 4'b1001;
  localparam logic [3:0] c_OP_BEQ  = 4'b1100;

  // ALU operation codes
  localparam logic [2:0] c_ALU_ADD  = 3'b000;
  localparam logic [2:0] c_ALU_NAND = 3'b001;
  localparam logic [2:0] c_ALU_SUB  = 3'b010;
  localparam logic [2:0] c_ALU_PASSB = 3'b011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_RTEX   = STATE_W'(6),
    S_RTWB   = STATE_W'(7),
    S_ADIEX  = STATE_W'(8),
    S_ADIWB  = STATE_W'(9),
    S_LHIWB  = STATE_W'(10),
    S_BEQEX  = STATE_W'(11),
    S_JALEX  = STATE_W'(12),
    S_JLREX  = STATE_W'(13)
  } state_t;

  state_t r_state;
  state_t w_next;

  logic       w_wb_ok;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_flagwrite;
  logic       w_alusrca;
  logic       w_iord;
  logic       w_memtoreg;
  logic [1:0] w_regdst;
  logic [1:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic [2:0] w_alucontrol;
  logic       w_illegal;

  // Writeback qualifier taken from the condition field of the instruction
`ifdef COND_WB_EN
  always_comb begin
    w_wb_ok = 1'b1;
    case (bus.cz)
      2'b00:   w_wb_ok = 1'b1;
      2'b01:   w_wb_ok = bus.zero_flag;
      2'b10:   w_wb_ok = bus.carry_flag;
      default: w_wb_ok = 1'b0;
    endcase
  end
`else
  // Condition field ignored: ADD/NAND always write back and update flags
  always_comb begin
    w_wb_ok = 1'b1;
  end
`endif

  // State register; reset returns to FETCH, which abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode, which depend on the state only (except for illegal, ALU op, wb_ok)
  always_comb begin
    w_next       = S_FETCH;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_regwrite   = 1'b0;
    w_flagwrite  = 1'b0;
    w_alusrca    = 1'b0;
    w_iord       = 1'b0;
    w_memtoreg   = 1'b0;
    w_regdst     = 2'b00;
    w_alusrcb    = 2'b00;
    w_pcsrc      = 2'b00;
    w_alucontrol = c_ALU_ADD;
    w_illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        // IR <= mem[PC], PC <= PC + 1
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode dispatches
        w_alusrcb = 2'b10;
        case (bus.op)
          c_OP_LW, c_OP_SW:    w_next = S_MEMADR;
          c_OP_ADD, c_OP_NAND: w_next = S_RTEX;
          c_OP_ADI:            w_next = S_ADIEX;
          c_OP_LHI:            w_next = S_LHIWB;
          c_OP_BEQ:            w_next = S_BEQEX;
          c_OP_JAL:            w_next = S_JALEX;
          c_OP_JLR:            w_next = S_JLREX;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        if (bus.op == c_OP_LW) begin
          w_next = S_MEMRD;
        end else if (bus.op == c_OP_SW) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_regdst   = 2'b00;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_RTEX: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b00;
        w_alucontrol = (bus.op == c_OP_NAND) ? c_ALU_NAND : c_ALU_ADD;
        w_flagwrite  = w_wb_ok;
        w_next       = S_RTWB;
      end
      S_RTWB: begin
        w_regwrite = w_wb_ok;
        w_regdst   = 2'b01;
        w_next     = S_FETCH;
      end
      S_ADIEX: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_flagwrite = 1'b1;
        w_next      = S_ADIWB;
      end
      S_ADIWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 2'b00;
        w_next     = S_FETCH;
      end
      S_LHIWB: begin
        // The ALU passes imm9 << 7 straight to the register file
        w_alusrcb    = 2'b11;
        w_alucontrol = c_ALU_PASSB;
        w_regwrite   = 1'b1;
        w_regdst     = 2'b00;
        w_next       = S_FETCH;
      end
      S_BEQEX: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = 2'b00;
        w_alucontrol = c_ALU_SUB;
        w_branch     = 1'b1;
        w_pcsrc      = 2'b01;
        w_next       = S_FETCH;
      end
      S_JALEX: begin
        // Link value is the already-incremented PC; target comes from ALUOut
        w_regwrite = 1'b1;
        w_regdst   = 2'b10;
        w_alusrcb  = 2'b01;
        w_pcsrc    = 2'b01;
        w_pcwrite  = 1'b1;
        w_next     = S_FETCH;
      end
      S_JLREX: begin
        w_regwrite = 1'b1;
        w_regdst   = 2'b10;
        w_pcsrc    = 2'b10;
        w_pcwrite  = 1'b1;
        w_next     = S_FETCH;
      end
      default: begin
        // Unused codes 14/15 recover to FETCH
        w_next = S_FETCH;
      end
    endcase
  end

  // Drive the bus; every output is held at zero while reset is asserted
  always_comb begin
    bus.pcen       = w_pcwrite | (w_branch & bus.zero);
    bus.memwrite   = w_memwrite;
    bus.irwrite    = w_irwrite;
    bus.regwrite   = w_regwrite;
    bus.flagwrite  = w_flagwrite;
    bus.alusrca    = w_alusrca;
    bus.iord       = w_iord;
    bus.memtoreg   = w_memtoreg;
    bus.regdst     = w_regdst;
    bus.alusrcb    = w_alusrcb;
    bus.pcsrc      = w_pcsrc;
    bus.alucontrol = w_alucontrol;
    bus.illegal    = w_illegal;
    bus.dbg_state  = r_state;
    if (reset) begin
      bus.pcen       = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.regwrite   = 1'b0;
      bus.flagwrite  = 1'b0;
      bus.alusrca    = 1'b0;
      bus.iord       = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regdst     = 2'b00;
      bus.alusrcb    = 2'b00;
      bus.pcsrc      = 2'b00;
      bus.alucontrol = 3'b000;
      bus.illegal    = 1'b0;
      bus.dbg_state  = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control_fsm
//  Purpose  : Directed self-checking bench for mc_control_fsm. Each task runs
//             one instruction scenario and compares outputs with
//             hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_control_fsm;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mc_control_fsm_if #(.STATE_W(4)) bus ();

  mc_control_fsm #(.STATE_W(4), .RESET_VEC_SEL(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs settle and outputs are sampled mid-low-phase
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Concatenation of every output of the control unit, 22 bits wide
  function automatic logic [21:0] all_outs();
    return {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.flagwrite,
            bus.alusrca, bus.iord, bus.memtoreg, bus.regdst, bus.alusrcb,
            bus.pcsrc, bus.alucontrol, bus.illegal, bus.dbg_state};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.op = 4'b1111; bus.cz = 2'b11; bus.zero = 1'b1;
    bus.carry_flag = 1'b1; bus.zero_flag = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (all_outs() !== 22'd0) begin
        n_errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, all_outs());
      end
    end
    reset = 1'b0;
    bus.op = 4'b0000; bus.cz = 2'b00; bus.zero = 1'b0;
    bus.carry_flag = 1'b0; bus.zero_flag = 1'b0;
    #1;
    n_checks++;
    if ({bus.dbg_state, bus.irwrite, bus.pcen, bus.alusrcb, bus.iord} !== {4'd0, 1'b1, 1'b1, 2'b01, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_release_fetch got st=%0d ir=%b pcen=%b srcb=%b iord=%b exp st=0 ir=1 pcen=1 srcb=01 iord=0",
               bus.dbg_state, bus.irwrite, bus.pcen, bus.alusrcb, bus.iord);
    end
  endtask

  task automatic test_add();
    logic [3:0] seq [5];
    seq = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    bus.op = 4'b0000; bus.cz = 2'b00;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_checks++;
      if (bus.dbg_state !== seq[i]) begin
        n_errors++;
        $display("FAIL add_state idx=%0d got=%0d exp=%0d", i, bus.dbg_state, seq[i]);
      end
      if (i == 2) begin
        n_checks++;
        if ({bus.flagwrite, bus.alucontrol, bus.alusrca, bus.alusrcb} !== {1'b1, 3'b000, 1'b1, 2'b00}) begin
          n_errors++;
          $display("FAIL add_rtex got fw=%b alu=%b srca=%b srcb=%b exp fw=1 alu=000 srca=1 srcb=00",
                   bus.flagwrite, bus.alucontrol, bus.alusrca, bus.alusrcb);
        end
      end
      if (i == 3) begin
        n_checks++;
        if ({bus.regwrite, bus.regdst, bus.memtoreg} !== {1'b1, 2'b01, 1'b0}) begin
          n_errors++;
          $display("FAIL add_rtwb got rw=%b rd=%b m2r=%b exp rw=1 rd=01 m2r=0",
                   bus.regwrite, bus.regdst, bus.memtoreg);
        end
      end
    end
  endtask

  task automatic test_nand();
    bus.op = 4'b0010; bus.cz = 2'b00;
    step(); step();
    n_checks++;
    if ({bus.dbg_state, bus.alucontrol} !== {4'd6, 3'b001}) begin
      n_errors++;
      $display("FAIL nand_rtex got st=%0d alu=%b exp st=6 alu=001", bus.dbg_state, bus.alucontrol);
    end
    step(); step();
  endtask

  task automatic test_lw_sw();
    logic [3:0] lw_seq [6];
    logic [3:0] sw_seq [5];
    lw_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    sw_seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    bus.op = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      n_checks++;
      if (bus.dbg_state !== lw_seq[i] || bus.memwrite !== 1'b0) begin
        n_errors++;
        $display("FAIL lw_state idx=%0d got st=%0d mw=%b exp st=%0d mw=0", i, bus.dbg_state, bus.memwrite, lw_seq[i]);
      end
      if (i == 3) begin
        n_checks++;
        if (bus.iord !== 1'b1) begin
          n_errors++;
          $display("FAIL lw_memrd_iord got=%b exp=1", bus.iord);
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({bus.regwrite, bus.memtoreg, bus.regdst} !== {1'b1, 1'b1, 2'b00}) begin
          n_errors++;
          $display("FAIL lw_memwb got rw=%b m2r=%b rd=%b exp rw=1 m2r=1 rd=00",
                   bus.regwrite, bus.memtoreg, bus.regdst);
        end
      end
    end
    bus.op = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_checks++;
      if (bus.dbg_state !== sw_seq[i] || bus.memwrite !== (i == 3) || bus.regwrite !== 1'b0) begin
        n_errors++;
        $display("FAIL sw_state idx=%0d got st=%0d mw=%b rw=%b exp st=%0d mw=%b rw=0",
                 i, bus.dbg_state, bus.memwrite, bus.regwrite, sw_seq[i], (i == 3));
      end
      if (i == 3) begin
        n_checks++;
        if (bus.iord !== 1'b1) begin
          n_errors++;
          $display("FAIL sw_memwr_iord got=%b exp=1", bus.iord);
        end
      end
    end
  endtask

  task automatic test_beq();
    logic z;
    bus.op = 4'b1100;
    for (int k = 0; k < 2; k++) begin
      z = (k == 0);
      bus.zero = z;
      step();
      n_checks++;
      if ({bus.dbg_state, bus.pcen} !== {4'd1, 1'b0}) begin
        n_errors++;
        $display("FAIL beq_decode_pcen z=%b got st=%0d pcen=%b exp st=1 pcen=0", z, bus.dbg_state, bus.pcen);
      end
      step();
      n_checks++;
      if ({bus.dbg_state, bus.pcen, bus.alucontrol, bus.pcsrc} !== {4'd11, z, 3'b010, 2'b01}) begin
        n_errors++;
        $display("FAIL beq_ex z=%b got st=%0d pcen=%b alu=%b pcsrc=%b exp st=11 pcen=%b alu=010 pcsrc=01",
                 z, bus.dbg_state, bus.pcen, bus.alucontrol, bus.pcsrc, z);
      end
      step();
      n_checks++;
      if (bus.dbg_state !== 4'd0) begin
        n_errors++;
        $display("FAIL beq_return z=%b got st=%0d exp st=0", z, bus.dbg_state);
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_jumps_lhi_adi();
    // JAL: 0,1,12,0
    bus.op = 4'b1000;
    step(); step();
    n_checks++;
    if ({bus.dbg_state, bus.regwrite, bus.regdst, bus.pcsrc, bus.pcen, bus.alusrcb} !== {4'd12, 1'b1, 2'b10, 2'b01, 1'b1, 2'b01}) begin
      n_errors++;
      $display("FAIL jal_ex got st=%0d rw=%b rd=%b pcsrc=%b pcen=%b srcb=%b exp st=12 rw=1 rd=10 pcsrc=01 pcen=1 srcb=01",
               bus.dbg_state, bus.regwrite, bus.regdst, bus.pcsrc, bus.pcen, bus.alusrcb);
    end
    step();
    // JLR: 0,1,13,0
    bus.op = 4'b1001;
    step(); step();
    n_checks++;
    if ({bus.dbg_state, bus.regwrite, bus.regdst, bus.pcsrc, bus.pcen} !== {4'd13, 1'b1, 2'b10, 2'b10, 1'b1}) begin
      n_errors++;
      $display("FAIL jlr_ex got st=%0d rw=%b rd=%b pcsrc=%b pcen=%b exp st=13 rw=1 rd=10 pcsrc=10 pcen=1",
               bus.dbg_state, bus.regwrite, bus.regdst, bus.pcsrc, bus.pcen);
    end
    step();
    // LHI: 0,1,10,0
    bus.op = 4'b0011;
    step(); step();
    n_checks++;
    if ({bus.dbg_state, bus.alusrcb, bus.alucontrol, bus.regwrite, bus.regdst} !== {4'd10, 2'b11, 3'b011, 1'b1, 2'b00}) begin
      n_errors++;
      $display("FAIL lhi_wb got st=%0d srcb=%b alu=%b rw=%b rd=%b exp st=10 srcb=11 alu=011 rw=1 rd=00",
               bus.dbg_state, bus.alusrcb, bus.alucontrol, bus.regwrite, bus.regdst);
    end
    step();
    // ADI: 0,1,8,9,0
    bus.op = 4'b0001;
    step(); step();
    n_checks++;
    if ({bus.dbg_state, bus.alusrca, bus.alusrcb, bus.flagwrite} !== {4'd8, 1'b1, 2'b10, 1'b1}) begin
      n_errors++;
      $display("FAIL adi_ex got st=%0d srca=%b srcb=%b fw=%b exp st=8 srca=1 srcb=10 fw=1",
               bus.dbg_state, bus.alusrca, bus.alusrcb, bus.flagwrite);
    end
    step();
    n_checks++;
    if ({bus.dbg_state, bus.regwrite, bus.regdst} !== {4'd9, 1'b1, 2'b00}) begin
      n_errors++;
      $display("FAIL adi_wb got st=%0d rw=%b rd=%b exp st=9 rw=1 rd=00", bus.dbg_state, bus.regwrite, bus.regdst);
    end
    step();
    n_checks++;
    if (bus.dbg_state !== 4'd0) begin
      n_errors++;
      $display("FAIL adi_return got st=%0d exp st=0", bus.dbg_state);
    end
  endtask

  task automatic test_cond_wb();
    logic exp_en;
`ifdef COND_WB_EN
    exp_en = 1'b0;
`else
    exp_en = 1'b1;
`endif
    bus.op = 4'b0000; bus.cz = 2'b01; bus.zero_flag = 1'b0; bus.carry_flag = 1'b1;
    step(); step();
    n_checks++;
    if ({bus.dbg_state, bus.flagwrite} !== {4'd6, exp_en}) begin
      n_errors++;
      $display("FAIL condwb_rtex got st=%0d fw=%b exp st=6 fw=%b", bus.dbg_state, bus.flagwrite, exp_en);
    end
    step();
    n_checks++;
    if ({bus.dbg_state, bus.regwrite} !== {4'd7, exp_en}) begin
      n_errors++;
      $display("FAIL condwb_rtwb got st=%0d rw=%b exp st=7 rw=%b", bus.dbg_state, bus.regwrite, exp_en);
    end
    step();
    bus.cz = 2'b00; bus.carry_flag = 1'b0;
  endtask

  task automatic test_illegal();
    logic [3:0] seq [3];
    seq = '{4'd0, 4'd1, 4'd0};
    bus.op = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      n_checks++;
      if (bus.dbg_state !== seq[i] || bus.illegal !== (i == 1)) begin
        n_errors++;
        $display("FAIL illegal_seq idx=%0d got st=%0d ill=%b exp st=%0d ill=%b",
                 i, bus.dbg_state, bus.illegal, seq[i], (i == 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.op = 4'b0101;
    step(); step(); step();
    n_checks++;
    if ({bus.dbg_state, bus.memwrite} !== {4'd5, 1'b1}) begin
      n_errors++;
      $display("FAIL rstmid_pre got st=%0d mw=%b exp st=5 mw=1", bus.dbg_state, bus.memwrite);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.memwrite !== 1'b0 || all_outs() !== 22'd0) begin
      n_errors++;
      $display("FAIL rstmid_during got mw=%b outs=%h exp mw=0 outs=0", bus.memwrite, all_outs());
    end
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.dbg_state, bus.irwrite, bus.memwrite} !== {4'd0, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL rstmid_after got st=%0d ir=%b mw=%b exp st=0 ir=1 mw=0",
               bus.dbg_state, bus.irwrite, bus.memwrite);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_add();
    test_nand();
    test_lw_sw();
    test_beq();
    test_jumps_lhi_adi();
    test_cond_wb();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
